// File: rtl/delay_align.sv
// delay_align: measures marker skew between streams A and B and delays the leading stream to align them.
// Define DELAY_ALIGN_DRIFT_EN to keep re-measuring while locked and flag skew drift.
module delay_align #(
  parameter  int SW   = 8,
  parameter  int DMAX = 64,
  localparam int AW   = $clog2(DMAX)
) (
  input  logic          Ck,
  input  logic          Rst_n,
  input  logic          CE,
  input  logic          Start,
  input  logic          MA,
  input  logic [SW-1:0] DA,
  input  logic          MB,
  input  logic [SW-1:0] DB,
  output logic [SW-1:0] QA,
  output logic [SW-1:0] QB,
  output logic          Lock,
  output logic [AW-1:0] Skew,
  output logic          Early,
  output logic          Err,
  output logic          Drift
);

  typedef enum logic [1:0] {IDLE, ARM, COUNT, LOCK} state_t;
  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0] CNT_LAST = (AW+1)'(DMAX-1);

  state_t        state, state_nx;
  logic [AW:0]   cnt, cnt_nx;
  logic [AW-1:0] skew_nx;
  logic          early_nx, err_nx;
  logic          trail;

  // Once Early is latched, the trailing marker is the one on the lagging stream.
  assign trail = Early ? MB : MA;
  assign Lock  = (state == LOCK);

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    skew_nx  = Skew;
    early_nx = Early;
    err_nx   = Err;
    if (Start) begin
      state_nx = ARM;
      err_nx   = 1'b0;
    end else begin
      case (state)
        ARM: begin
          if (MA && MB) begin
            skew_nx  = '0;
            early_nx = 1'b0;
            state_nx = LOCK;
          end else if (MA || MB) begin
            early_nx = MA;
            cnt_nx   = CNT_ONE;
            state_nx = COUNT;
          end
        end
        COUNT: begin
          cnt_nx = cnt + CNT_ONE;
          if (trail) begin
            skew_nx  = cnt[AW-1:0];
            state_nx = LOCK;
          end else if (cnt == CNT_LAST) begin
            err_nx   = 1'b1;
            state_nx = IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge Ck or negedge Rst_n) begin
    if (!Rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      Skew  <= '0;
      Early <= 1'b0;
      Err   <= 1'b0;
    end else if (CE) begin
      state <= state_nx;
      cnt   <= cnt_nx;
      Skew  <= skew_nx;
      Early <= early_nx;
      Err   <= err_nx;
    end
  end

  // Delay line carries whichever stream Early names as leading; unreset by design.
  logic [SW-1:0] mem [DMAX];
  logic [AW-1:0] wptr, raddr;
  logic [SW-1:0] dly;
  logic          dly_a, dly_b;

  assign raddr = wptr - Skew;
  assign dly   = mem[raddr];
  assign dly_a = Lock && Early  && (Skew != '0);
  assign dly_b = Lock && !Early && (Skew != '0);

  always_ff @(posedge Ck) begin
    if (CE) mem[wptr] <= Early ? DA : DB;
  end

  always_ff @(posedge Ck or negedge Rst_n) begin
    if (!Rst_n) begin
      wptr <= '0;
      QA   <= '0;
      QB   <= '0;
    end else if (CE) begin
      wptr <= wptr + AW'(1);
      QA   <= dly_a ? dly : DA;
      QB   <= dly_b ? dly : DB;
    end
  end

`ifdef DELAY_ALIGN_DRIFT_EN
  // Shadow measurement while locked; only Drift observes its outcome.
  logic        m_act, m_act_nx, m_early, m_early_nx, drift_q, drift_nx;
  logic [AW:0] m_cnt, m_cnt_nx;

  always_comb begin
    m_act_nx   = m_act;
    m_early_nx = m_early;
    m_cnt_nx   = m_cnt;
    drift_nx   = drift_q;
    if (Start) begin
      m_act_nx = 1'b0;
      drift_nx = 1'b0;
    end else if (state != LOCK) begin
      m_act_nx = 1'b0;
    end else if (!m_act) begin
      if (MA && MB) begin
        if (Skew != '0 || Early) drift_nx = 1'b1;
      end else if (MA || MB) begin
        m_act_nx   = 1'b1;
        m_early_nx = MA;
        m_cnt_nx   = CNT_ONE;
      end
    end else begin
      m_cnt_nx = m_cnt + CNT_ONE;
      if (m_early ? MB : MA) begin
        m_act_nx = 1'b0;
        if (m_cnt[AW-1:0] != Skew || m_early != Early) drift_nx = 1'b1;
      end else if (m_cnt == CNT_LAST) begin
        m_act_nx = 1'b0;
        drift_nx = 1'b1;
      end
    end
  end

  always_ff @(posedge Ck or negedge Rst_n) begin
    if (!Rst_n) begin
      m_act   <= 1'b0;
      m_early <= 1'b0;
      m_cnt   <= '0;
      drift_q <= 1'b0;
    end else if (CE) begin
      m_act   <= m_act_nx;
      m_early <= m_early_nx;
      m_cnt   <= m_cnt_nx;
      drift_q <= drift_nx;
    end
  end

  assign Drift = drift_q;
`else
  assign Drift = 1'b0;
`endif

endmodule

// File: doc/delay_align.md
DELAY_ALIGN -- requirements
Module: Delay_align

Interface
REQ-001 SHALL have parameter SW, default 8, meaning data width of each stream (>=1).
REQ-002 SHALL have parameter DMAX, default 64, meaning buffer depth and maximum measurable skew + 1 (power of 2, >=4); AW = clog2(DMAX).
REQ-003 SHALL have ports:
- Ck  input  1  clock, rising edge.
- Rst_n  input  1  asynchronous active-low reset.
- CE  input  1  clock enable.
- Start  input  1  begin skew measurement.
- MA  input  1  marker on stream A.
- DA  input  SW  stream A data.
- MB  input  1  marker on stream B.
- DB  input  SW  stream B data.
- QA  output  SW  aligned stream A.
- QB  output  SW  aligned stream B.
- Lock  output  1  skew measured and applied.
- Skew  output  AW  measured skew in CE cycles.
- Early  output  1  1 = A leads B, 0 = B leads or equal.
- Err  output  1  measurement timeout, sticky until Start.
- Drift  output  1  skew change detected while locked.

Function
REQ-004 SHALL advance all state, counters, pointers and output registers only on rising Ck with CE=1; CE=0 holds everything.
REQ-005 SHALL implement FSM IDLE -> ARM -> COUNT -> LOCK.
- IDLE: Start -> ARM.
- ARM: first marker seen -> COUNT.
- COUNT: other marker seen -> LOCK.
- COUNT: timeout -> IDLE with Err=1.
REQ-006 In ARM, MA and MB both 1 in the same cycle SHALL go directly to LOCK with Skew=0, Early=0.
REQ-007 In ARM, a single marker SHALL latch Early (1 if MA), clear the counter to 1 and enter COUNT.
REQ-008 In COUNT, the counter SHALL increment per CE cycle; repeats of the leading marker are ignored; the trailing marker latches Skew = counter value and enters LOCK.
REQ-009 In COUNT, counter reaching DMAX with no trailing marker SHALL set Err=1, Lock=0, state IDLE.
REQ-010 Start in any state (including ARM, COUNT, LOCK) SHALL clear Err, Drift and Lock next cycle and enter ARM; Skew/Early hold until re-latched.
REQ-011 Lock SHALL be 1 exactly while in LOCK.
REQ-012 Output latency: QA(n+1) = DA(n - dA), QB(n+1) = DB(n - dB), with n counted in CE cycles.
- Lock=1: the leading stream's d = Skew; the other stream's d = 0.
- Lock=0: dA = dB = 0 (one-register passthrough).
REQ-013 The leading stream SHALL be delayed through a DMAX-entry circular buffer.
- Write pointer increments every CE cycle, wrapping modulo DMAX.
- Read address = wptr - Skew, modulo DMAX.
- Skew=0 bypasses the buffer.
REQ-014 Buffer contents SHALL not be reset; for the first Skew cycles after Lock rises, QA/QB of the delayed stream are undefined-but-stable data (not X-propagating control).
REQ-015 Skew output SHALL be AW bits; the maximum locked value is DMAX-1.

Reset
REQ-016 Rst_n=0 SHALL asynchronously force:
- state IDLE;
- QA=0, QB=0;
- Lock=0, Skew=0, Early=0, Err=0, Drift=0;
- wptr=0, counter=0.
REQ-017 Reset release SHALL take effect on the first rising Ck with Rst_n=1; no Start is implied.

Configuration
REQ-018 Macro DELAY_ALIGN_DRIFT_EN defined: in LOCK the block SHALL re-measure the marker spacing with the same rules.
- A result differing in Skew or Early, or a timeout, sets Drift=1 (sticky until Start or reset).
- Applied Skew and Lock are unchanged.
REQ-019 Macro DELAY_ALIGN_DRIFT_EN undefined: markers SHALL be ignored in LOCK and Drift SHALL be tied 0.

Verification
REQ-020 Reset mid-COUNT with Skew=5 latched earlier -> all outputs 0 immediately, state IDLE after release.
REQ-021 Start, MA at n=10, MB at n=13 -> Lock=1, Skew=3, Early=1; DB passes with 1-cycle latency; QA(k+1)=DA(k-3) checked over 100 random words.
REQ-022 Start, MA and MB same cycle -> Skew=0, Early=0, Lock=1; QA/QB both 1-cycle latency.
REQ-023 Start, MB only, DMAX=64 -> Err=1 after 64 CE cycles, Lock=0; a new Start clears Err.
REQ-024 CE toggled 50% during a Skew=7 B-leads run -> QB alignment holds in CE cycles; Skew=DMAX-1=63 wraps correctly.
REQ-025 With DELAY_ALIGN_DRIFT_EN, locked at Skew=3, then markers at spacing 4 -> Drift=1, Skew stays 3; without the macro -> Drift stays 0.
